omem_frame_buf: RTL and testbench
=================================

Name: omem_frame_buf

Overview:
Parametrised output spike memory for NUM_CORES neuron cores. Each core has a Wishbone-readable window of spike words. Each core's window is double-buffered: the back buffer captures spikes while the core computes, and on end-of-calculation it swaps into the front buffer read by the host. Per-core status counts frames, flags overruns and drives a level interrupt, so the host can read results without racing the cores.

Parameters:
NUM_CORES, 2, number of neuron cores served (1..16)
NUM_NEURONS, 256, spike bits per core; multiple of 32, max 1024
OMEM_BASE, 32'h80040000, byte address of core 0 window
CORE_STRIDE, 32'h00010000, byte distance between core windows

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane select
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
enable_calc_i  in  NUM_CORES  per-core calculation active
spike_neuron_i  in  NUM_CORES*NUM_NEURONS  core c spikes at [c*NUM_NEURONS +: NUM_NEURONS]
frame_irq_o  out  NUM_CORES  per-core frame-ready interrupt, level

Behaviour:
- Clock/reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset clears:
  - wbs_ack_o=0, wbs_dat_o=0, frame_irq_o=0.
  - All buffers = 0, and all STATUS/CTRL fields = 0.
  - Any in-flight bus access is dropped, with no ack.
- WORDS = NUM_NEURONS/32.
- Window decode:
  - Core c window is [OMEM_BASE + c*CORE_STRIDE, +CORE_STRIDE).
  - off = adr - window base.
  - off 0x000..4*(WORDS-1): spike words, read-only. Word k = front[NUM_NEURONS-1-32k -: 32], so word 0 holds the MSBs.
  - off 0x400: STATUS. bit0 frame_valid, bit1 overflow, bits[31:16] frame_count, other bits 0.
  - off 0x404: CTRL. bit0 irq_en, other bits read 0.
  - Any other address, including outside all windows, is unmapped.
  - wbs_adr_i[1:0] is ignored.
- Wishbone:
  - wbs_ack_o <= cyc & stb & ~wbs_ack_o. This gives a one-cycle ack pulse one cycle after request, so back-to-back strobes are acked every other cycle.
  - wbs_dat_o is registered with the ack and is 0 for writes and unmapped reads.
  - Writes take effect in the request cycle only when ~wbs_ack_o, so each access has exactly one effect.
  - Writes to spike words or unmapped addresses are acked and ignored.
  - CTRL write honours wbs_sel_i[0].
  - STATUS write is write-1-to-clear for bits0/1, gated by wbs_sel_i[0]. frame_count is read-only.
- Capture, per core, independent:
  - Every cycle enable_calc_i[c]=1, back_c <= core c spike slice.
  - Capture is never blocked by bus traffic.
- Swap, per core:
  - Swap occurs on the falling edge of enable_calc_i[c], detected from a registered copy; the swap cycle is the first cycle enable is 0.
  - In the swap cycle: front_c <= back_c, frame_valid <= 1, frame_count <= frame_count+1 (wraps 0xFFFF->0).
  - If frame_valid was already 1 at the swap, overflow <= 1. overflow is sticky until cleared.
- Simultaneous events:
  - Swap and STATUS W1C in the same cycle: set wins (frame_valid=1; overflow per rule above).
  - Read of a spike word in the swap cycle returns the pre-swap front data.
  - Reset asserted while enable_calc_i=1: no swap on the next cycle, because the registered enable resets to 0.
- frame_irq_o[c] = frame_valid & irq_en, registered.
- Latency: spike data becomes host-visible 1 cycle after enable falls. Read latency is 1 cycle.

Test Plan:
- Reset, then read core0 word0 and STATUS -> both 0x00000000, one ack per access, frame_irq_o=0.
- Core0 spikes all-ones on bits[255:224], enable 1 for 3 cycles then 0 -> word0=0xFFFFFFFF, word7=0, STATUS=0x00010001.
- Two frames on core1 without clearing -> STATUS=0x00020003. Write 0x3 to STATUS -> 0x00020000.
- CTRL irq_en=1, one core0 frame -> frame_irq_o=2'b01 two cycles after enable falls. W1C bit0 -> irq drops the cycle after ack.
- Swap and STATUS W1C issued in the same cycle -> frame_valid remains 1 and frame_count increments.
- Write 0xDEADBEEF to a spike word, CTRL with sel=4'b1110, and address 0x80060000 -> all acked, no state change, unmapped read returns 0.

Source files
------------

// File: rtl/omem_frame_buf.sv
// Double-buffered per-core spike output memory with a Wishbone read window,
// frame status/overrun tracking and a level frame-ready interrupt per core.
module omem_frame_buf #(
   parameter int unsigned NUM_CORES   = 2,
   parameter int unsigned NUM_NEURONS = 256,
   parameter logic [31:0] OMEM_BASE   = 32'h8004_0000,
   parameter logic [31:0] CORE_STRIDE = 32'h0001_0000
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_i,
   input  logic                             wbs_cyc_i,
   input  logic                             wbs_stb_i,
   input  logic                             wbs_we_i,
   input  logic [3:0]                       wbs_sel_i,
   input  logic [31:0]                      wbs_adr_i,
   input  logic [31:0]                      wbs_dat_i,
   output logic                             wbs_ack_o,
   output logic [31:0]                      wbs_dat_o,
   input  logic [NUM_CORES-1:0]             enable_calc_i,
   input  logic [NUM_CORES*NUM_NEURONS-1:0] spike_neuron_i,
   output logic [NUM_CORES-1:0]             frame_irq_o
);

   localparam int unsigned WORDS      = NUM_NEURONS / 32;
   localparam logic [31:0] STATUS_OFF = 32'h0000_0400;
   localparam logic [31:0] CTRL_OFF   = 32'h0000_0404;

   logic                                  ack_q, ack_d;
   logic [31:0]                           dat_q, dat_d;
   logic [NUM_CORES-1:0]                  en_q, en_d;
   logic [NUM_CORES-1:0]                  fv_q, fv_d;
   logic [NUM_CORES-1:0]                  ov_q, ov_d;
   logic [NUM_CORES-1:0]                  irq_en_q, irq_en_d;
   logic [NUM_CORES-1:0]                  irq_q, irq_d;
   logic [NUM_CORES-1:0][15:0]            cnt_q, cnt_d;
   logic [NUM_CORES-1:0][NUM_NEURONS-1:0] back_q, back_d;
   logic [NUM_CORES-1:0][NUM_NEURONS-1:0] front_q, front_d;

   logic        req;
   logic [31:0] adr;
   logic [31:0] base;
   logic [31:0] off;
   logic        hit;
   logic        swap;
   logic [31:0] rd;

   // One effect per access: a request only counts while no ack is outstanding.
   always_comb begin
      req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
      adr      = {wbs_adr_i[31:2], 2'b00};
      ack_d    = req;
      rd       = '0;
      base     = '0;
      off      = '0;
      hit      = 1'b0;
      swap     = 1'b0;
      en_d     = enable_calc_i;
      fv_d     = fv_q;
      ov_d     = ov_q;
      irq_en_d = irq_en_q;
      irq_d    = fv_q & irq_en_q;
      cnt_d    = cnt_q;
      back_d   = back_q;
      front_d  = front_q;

      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         base = OMEM_BASE + 32'(c) * CORE_STRIDE;
         off  = adr - base;
         hit  = (adr >= base) && (off < CORE_STRIDE);
         swap = en_q[c] & ~enable_calc_i[c];

         if (enable_calc_i[c]) begin
            back_d[c] = spike_neuron_i[c*NUM_NEURONS +: NUM_NEURONS];
         end

         if (req && hit) begin
            if (!wbs_we_i) begin
               for (int unsigned w = 0; w < WORDS; w++) begin
                  if (off == 32'(4 * w)) begin
                     rd = front_q[c][NUM_NEURONS-1-32*w -: 32];
                  end
               end
               if (off == STATUS_OFF) rd = {cnt_q[c], 14'b0, ov_q[c], fv_q[c]};
               if (off == CTRL_OFF)   rd = {31'b0, irq_en_q[c]};
            end else if (wbs_sel_i[0]) begin
               if (off == STATUS_OFF) begin
                  if (wbs_dat_i[0]) fv_d[c] = 1'b0;
                  if (wbs_dat_i[1]) ov_d[c] = 1'b0;
               end
               if (off == CTRL_OFF) irq_en_d[c] = wbs_dat_i[0];
            end
         end

         // Swap is applied after the bus write so a simultaneous set wins over W1C.
         if (swap) begin
            front_d[c] = back_q[c];
            fv_d[c]    = 1'b1;
            cnt_d[c]   = cnt_q[c] + 16'd1;
            if (fv_q[c]) ov_d[c] = 1'b1;
         end
      end

      dat_d = (req && !wbs_we_i) ? rd : 32'h0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         en_q     <= '0;
         fv_q     <= '0;
         ov_q     <= '0;
         irq_en_q <= '0;
         irq_q    <= '0;
         cnt_q    <= '0;
         back_q   <= '0;
         front_q  <= '0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         en_q     <= en_d;
         fv_q     <= fv_d;
         ov_q     <= ov_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         cnt_q    <= cnt_d;
         back_q   <= back_d;
         front_q  <= front_d;
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign frame_irq_o = irq_q;

   // Byte-lane and data bits that no register consumes.
   logic unused_bits;
   assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:2], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_omem_frame_buf.sv
// Directed bench for omem_frame_buf: bus access, frame capture/swap,
// status W1C, interrupt timing and unmapped/ignored writes.
module tb_omem_frame_buf;

   localparam int unsigned NC = 2;
   localparam int unsigned NN = 256;
   localparam logic [31:0] C0 = 32'h8004_0000;
   localparam logic [31:0] C1 = 32'h8005_0000;
   localparam logic [31:0] ST = 32'h0000_0400;
   localparam logic [31:0] CT = 32'h0000_0404;

   logic             clk = 1'b0;
   logic             rst;
   logic             cyc, stb, we;
   logic [3:0]       sel;
   logic [31:0]      adr, wdat;
   logic             ack;
   logic [31:0]      rdat;
   logic [NC-1:0]    en;
   logic [NC*NN-1:0] spikes;
   logic [NC-1:0]    irq;
   logic [31:0]      rv;

   int checks = 0;
   int errors = 0;

   omem_frame_buf #(.NUM_CORES(NC), .NUM_NEURONS(NN)) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (rst),
      .wbs_cyc_i      (cyc),
      .wbs_stb_i      (stb),
      .wbs_we_i       (we),
      .wbs_sel_i      (sel),
      .wbs_adr_i      (adr),
      .wbs_dat_i      (wdat),
      .wbs_ack_o      (ack),
      .wbs_dat_o      (rdat),
      .enable_calc_i  (en),
      .spike_neuron_i (spikes),
      .frame_irq_o    (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Single access; drop clears enables in the same cycle as the request.
   task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [NC-1:0] drop,
                            output logic [31:0] r);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      en  = en & ~drop;
      @(posedge clk); #1;
      check_eq("ack", 32'(ack), 32'd1);
      r = rdat;
      if (w) check_eq("wr_dat_zero", rdat, 32'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check_eq("ack_single", 32'(ack), 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] r;
      wb_access(1'b0, a, 32'h0, 4'hF, '0, r);
      check_eq(tag, r, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      wb_access(1'b1, a, d, s, '0, r);
   endtask

   task automatic start_frame(input int c, input logic [NN-1:0] v);
      @(negedge clk);
      spikes[c*NN +: NN] = v;
      en[c] = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic end_frame(input int c);
      @(negedge clk);
      en[c] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = '0; wdat = '0; spikes = '0; en = '0;

      // Reset held with enable high: no swap may follow.
      @(negedge clk);
      en[0] = 1'b1;
      spikes[NN-1:0] = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; en = '0; spikes = '0;
      @(posedge clk); #1;
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_dat", rdat, 32'h0);
      check_eq("rst_irq", 32'(irq), 32'd0);
      rd_chk("rst_word0", C0, 32'h0);
      rd_chk("rst_status", C0 + ST, 32'h0);
      check_eq("rst_irq2", 32'(irq), 32'd0);

      // Core 0 frame with the top word set.
      start_frame(0, {32'hFFFF_FFFF, 224'h0});
      end_frame(0);
      rd_chk("c0_word0", C0, 32'hFFFF_FFFF);
      rd_chk("c0_word7", C0 + 32'h1C, 32'h0);
      rd_chk("c0_status1", C0 + ST, 32'h0001_0001);

      // Two core 1 frames without clearing -> overflow.
      start_frame(1, {32'h0, 32'hA5A5_0F0F, 160'h0, 32'h1234_5678});
      end_frame(1);
      rd_chk("c1_word1", C1 + 32'h4, 32'hA5A5_0F0F);
      rd_chk("c1_word7", C1 + 32'h1C, 32'h1234_5678);
      start_frame(1, {32'hCAFE_F00D, 224'h0});
      end_frame(1);
      rd_chk("c1_word0", C1, 32'hCAFE_F00D);
      rd_chk("c1_word7b", C1 + 32'h1C, 32'h0);
      rd_chk("c1_status2", C1 + ST, 32'h0002_0003);
      rd_chk("c0_status_iso", C0 + ST, 32'h0001_0001);
      wr(C1 + ST, 32'h3, 4'hF);
      rd_chk("c1_status_clr", C1 + ST, 32'h0002_0000);

      // Interrupt timing on core 0.
      wr(C0 + ST, 32'h1, 4'hF);
      wr(C0 + CT, 32'h1, 4'hF);
      rd_chk("c0_ctrl", C0 + CT, 32'h1);
      check_eq("irq_idle", 32'(irq), 32'd0);
      start_frame(0, '0);
      @(negedge clk);
      en[0] = 1'b0;
      @(posedge clk); #1;
      check_eq("irq_plus1", 32'(irq), 32'd0);
      @(posedge clk); #1;
      check_eq("irq_plus2", 32'(irq), 32'd1);
      rd_chk("c0_status2", C0 + ST, 32'h0002_0001);
      wr(C0 + ST, 32'h1, 4'hF);
      check_eq("irq_cleared", 32'(irq), 32'd0);
      rd_chk("c0_status2c", C0 + ST, 32'h0002_0000);

      // Swap coincident with W1C: set wins.
      start_frame(0, {32'h1111_1111, 224'h0});
      end_frame(0);
      rd_chk("c0_status3", C0 + ST, 32'h0003_0001);
      start_frame(0, {32'h2222_2222, 224'h0});
      wb_access(1'b1, C0 + ST, 32'h3, 4'hF, 2'b01, rv);
      rd_chk("swap_w1c_status", C0 + ST, 32'h0004_0003);
      check_eq("swap_w1c_irq", 32'(irq), 32'd1);

      // Read during the swap cycle sees the old front.
      start_frame(0, {32'h3333_3333, 224'h0});
      wb_access(1'b0, C0, 32'h0, 4'hF, 2'b01, rv);
      check_eq("swap_read_old", rv, 32'h2222_2222);
      rd_chk("swap_read_new", C0, 32'h3333_3333);
      rd_chk("c0_status5", C0 + ST, 32'h0005_0003);

      // Ignored writes and unmapped addresses.
      wr(C0, 32'hDEAD_BEEF, 4'hF);
      rd_chk("spike_ro", C0, 32'h3333_3333);
      wr(C0 + CT, 32'h0, 4'b1110);
      rd_chk("ctrl_sel", C0 + CT, 32'h1);
      wr(C0 + ST, 32'h3, 4'b1110);
      rd_chk("status_sel", C0 + ST, 32'h0005_0003);
      wr(32'h8006_0000, 32'hFFFF_FFFF, 4'hF);
      rd_chk("unmapped_out", 32'h8006_0000, 32'h0);
      rd_chk("unmapped_in", C0 + 32'h20, 32'h0);
      rd_chk("adr_lsb_ign", C0 + 32'h3, 32'h3333_3333);
      check_eq("irq_final", 32'(irq), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
